// File: rtl/sum_n_arbiter_pkg.sv
// sum_n_pkg: FSM state codes and the requester-id width helper
// shared by the sum_n_arbiter slice.
package sum_n_pkg;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   // Width of a requester index; never below one bit.
   function automatic int id_w(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/sum_n_arbiter_if.sv
// sum_n_arbiter_if: request/response handshake bundle between
// the requesters/consumer (master) and the arbiter (slave).
interface sum_n_arbiter_if #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
);
   import sum_n_pkg::*;

   localparam int ID_W = id_w(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_n;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic [ID_W-1:0]       rsp_id;
   logic [2*WIDTH-1:0]    rsp_result;
   logic                  rsp_ready;
   logic                  busy;

   modport master (
      output req_valid, req_n, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, busy
   );

   modport slave (
      input  req_valid, req_n, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, busy
   );

endinterface

// File: rtl/sum_n_arbiter_engine.sv
// sum_n_engine: iterative triangular-sum datapath. Loads n on start,
// adds i, i-1, ... 1 into sum, pulses done on the cycle i reaches 0.
module sum_n_engine #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_n,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_sum
);

   logic [WIDTH-1:0]   r_i;
   logic [2*WIDTH-1:0] r_sum;
   logic               r_active;

   // Load on start, then accumulate one term per cycle until i hits 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_i      <= '0;
         r_sum    <= '0;
         r_active <= 1'b0;
      end else if (i_start) begin
         r_i      <= i_n;
         r_sum    <= '0;
         r_active <= 1'b1;
      end else if (r_active) begin
         if (r_i != '0) begin
            r_sum <= r_sum + {{WIDTH{1'b0}}, r_i};
            r_i   <= r_i - WIDTH'(1);
         end else begin
            r_active <= 1'b0;
         end
      end
   end

   // Done is the single active cycle that sees i == 0.
   always_comb begin
      o_done = r_active && (r_i == '0);
      o_sum  = r_sum;
   end

endmodule

// File: rtl/sum_n_arbiter.sv
// sum_n_arbiter: round-robin front end sharing one sum_n_engine.
// Optional busy-cycle counter enabled by defining SUM_ARB_PERF_EN.
module sum_n_arbiter
   import sum_n_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
) (
   input  logic clk,
   input  logic reset,
   sum_n_arbiter_if.slave bus
`ifdef SUM_ARB_PERF_EN
   , output logic [31:0] perf_busy_cycles
`endif
);

   localparam int ID_W = id_w(NREQ);

   logic [1:0]         r_state;
   logic [1:0]         w_next;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [ID_W-1:0]    r_id;
   logic [ID_W-1:0]    w_gid;
   logic [ID_W-1:0]    w_j;
   logic [NREQ-1:0]    w_grant;
   logic               w_found;
   logic               w_accept;
   logic [WIDTH-1:0]   w_n;
   logic               w_done;
   logic [2*WIDTH-1:0] w_sum;

   // First pending requester at or after the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_gid   = '0;
      w_j     = '0;
      for (int o = 0; o < NREQ; o++) begin
         w_j = ID_W'((int'(r_rr_ptr) + o) % NREQ);
         if (!w_found && bus.req_valid[w_j]) begin
            w_found = 1'b1;
            w_gid   = w_j;
         end
      end
      w_grant  = w_found ? (NREQ'(1) << w_gid) : '0;
      w_accept = (r_state == IDLE) && w_found && !reset;
      w_n      = bus.req_n[int'(w_gid)*WIDTH +: WIDTH];
   end

   sum_n_engine #(
      .WIDTH (WIDTH)
   ) u_engine (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_accept),
      .i_n     (w_n),
      .o_done  (w_done),
      .o_sum   (w_sum)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_found)       w_next = RUN;
         RUN:     if (w_done)        w_next = DONE;
         DONE:    if (bus.rsp_ready) w_next = IDLE;
         default:                    w_next = IDLE;
      endcase
   end

   // Owner id and round-robin pointer, both updated only on accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr <= '0;
         r_id     <= '0;
      end else if (w_accept) begin
         r_id     <= w_gid;
         r_rr_ptr <= (int'(w_gid) == NREQ - 1) ? '0 : w_gid + ID_W'(1);
      end
   end

   // Outputs decoded from state; response fields are zero outside DONE.
   always_comb begin
      bus.req_ready  = '0;
      bus.rsp_valid  = 1'b0;
      bus.rsp_id     = '0;
      bus.rsp_result = '0;
      bus.busy       = 1'b0;
      unique case (r_state)
         IDLE: bus.req_ready = reset ? '0 : w_grant;
         RUN:  bus.busy      = 1'b1;
         DONE: begin
            bus.busy       = 1'b1;
            bus.rsp_valid  = 1'b1;
            bus.rsp_id     = r_id;
            bus.rsp_result = w_sum;
         end
         default: ;
      endcase
   end

`ifdef SUM_ARB_PERF_EN
   // Saturating count of busy cycles, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)
         perf_busy_cycles <= '0;
      else if (bus.busy && (perf_busy_cycles != 32'hFFFF_FFFF))
         perf_busy_cycles <= perf_busy_cycles + 32'd1;
   end
`endif

endmodule
